// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from N_REQ producers into one UART transmitter,
// holding tx_data for the whole frame and watching td_busy for completion or a stall.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW          = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 send,
  input  logic                 td_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 active,
  output logic                 frame_done,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic              send_q, send_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              found;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     cand;
  logic              timeout;

  // Search starts one past the previous winner so every requester gets its turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant_q) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    req_ready_d  = '0;
    send_d       = 1'b0;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    timeout      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!td_busy && found) begin
          tx_data_d           = req_data[{winner, 3'b000} +: 8];
          grant_d             = winner;
          last_grant_d        = winner;
          req_ready_d[winner] = 1'b1;
          send_d              = 1'b1;
          state_d             = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (td_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d >= 8'(BUSY_TIMEOUT)) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!td_busy) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh timeout outranks a simultaneous clear.
    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(N_REQ - 1);
      grant_q      <= '0;
      tx_data_q    <= 8'h00;
      req_ready_q  <= '0;
      send_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      send_q       <= send_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign send        = send_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a small UART transmitter model decodes TXD,
// and expected grants/bytes are queued at stimulus time and popped as the DUT acts.
module tb_uart_tx_arbiter;
  localparam int N_REQ   = 4;
  localparam int BT      = 16;
  localparam int GW      = $clog2(N_REQ);
  localparam int BIT_CYC = 2;

  typedef struct {
    logic [GW-1:0] id;
    logic [7:0]    data;
  } grant_t;

  logic                clk;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [8*N_REQ-1:0]  req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [7:0]          tx_data;
  logic                send;
  logic                td_busy;
  logic [GW-1:0]       grant_id;
  logic                active;
  logic                frame_done;
  logic                timeout_err;
  logic                err_clr;

  logic                force_busy;
  logic                stall_mode;

  logic                x_busy;
  logic [3:0]          x_bit;
  logic [3:0]          x_cyc;
  logic [9:0]          x_shift;
  logic [9:0]          rx_frame;
  logic                rx_done;
  logic                txd;

  int                  n_cmp = 0;
  int                  n_err = 0;
  grant_t              exp_grant[$];
  logic [7:0]          exp_tx[$];
  int                  fd_cnt = 0;
  int                  fd_expect = 0;
  logic                prev_send;
  logic [7:0]          last_data;

  uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .send        (send),
    .td_busy     (td_busy),
    .grant_id    (grant_id),
    .active      (active),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: reads tx_data live at every bit time and records the line it drives.
  assign td_busy = force_busy | (x_busy & ~stall_mode);
  assign txd = !x_busy       ? 1'b1 :
               (x_bit == 0)  ? 1'b0 :
               (x_bit == 9)  ? 1'b1 : tx_data[3'(x_bit - 4'd1)];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_busy   <= 1'b0;
      x_bit    <= '0;
      x_cyc    <= '0;
      x_shift  <= '0;
      rx_frame <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!x_busy) begin
        if (send && !stall_mode) begin
          x_busy <= 1'b1;
          x_bit  <= '0;
          x_cyc  <= '0;
        end
      end else begin
        if (x_cyc == '0) x_shift <= {txd, x_shift[9:1]};
        if (x_cyc == 4'(BIT_CYC - 1)) begin
          x_cyc <= '0;
          if (x_bit == 4'd9) begin
            x_busy   <= 1'b0;
            rx_done  <= 1'b1;
            rx_frame <= x_shift;
          end else begin
            x_bit <= x_bit + 4'd1;
          end
        end else begin
          x_cyc <= x_cyc + 4'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int id, input logic [7:0] d, input bit transmits);
    req_data[8*id +: 8] = d;
    req_valid[id]       = 1'b1;
    exp_grant.push_back('{GW'(id), d});
    if (transmits) begin
      exp_tx.push_back(d);
      fd_expect++;
    end
  endtask

  // One clock: sample at the falling edge, score sends, frames and completions.
  task automatic step();
    grant_t g;
    @(negedge clk);
    if (send) begin
      check("send_gap", prev_send, 0);
      if (exp_grant.size() == 0) begin
        check("unexpected_send", send, 0);
      end else begin
        g = exp_grant.pop_front();
        check("grant_id", grant_id, g.id);
        check("req_ready", req_ready, 1 << g.id);
        check("tx_data", tx_data, g.data);
        req_valid[g.id] = 1'b0;
        last_data       = g.data;
      end
    end else if (req_ready != '0) begin
      check("ready_without_send", req_ready, 0);
    end
    if (frame_done) begin
      fd_cnt++;
      check("done_tx_data_held", tx_data, last_data);
    end
    if (rx_done) begin
      check("frame_start_stop", {rx_frame[9], rx_frame[0]}, 2'b10);
      if (exp_tx.size() == 0) check("unexpected_frame", rx_frame[8:1], 32'hFFFF_FFFF);
      else                    check("txd_byte", rx_frame[8:1], exp_tx.pop_front());
    end
    prev_send = send;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (!(exp_grant.size() == 0 && exp_tx.size() == 0 && !active && !td_busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle"}, {active, td_busy, exp_grant.size() != 0, exp_tx.size() != 0}, 4'b0000);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_send"}, send, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    err_clr    = 1'b0;
    force_busy = 1'b0;
    stall_mode = 1'b0;
    prev_send  = 1'b0;
    last_data  = 8'h00;

    // Reset state
    repeat (2) step();
    check_reset_values("rst");
    reset = 1'b1;
    step();

    // Single request from requester 2; send one cycle after the request edge
    request(2, 8'hA5, 1);
    step();
    check("lat_send", send, 1);
    check("lat_ready", req_ready, 4'b0100);
    check("lat_active", active, 1);
    run_until_idle("single", 100);
    check("single_frames", fd_cnt, fd_expect);

    // All four requesting right after reset: rotation 0,1,2,3 then 0,2 then 3,1
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < N_REQ; i++) request(i, 8'($urandom_range(255)), 1);
    run_until_idle("rr4", 400);
    request(0, 8'h3E, 1);
    request(2, 8'hC1, 1);
    run_until_idle("rr02", 200);
    request(3, 8'h81, 1);
    request(1, 8'h18, 1);
    run_until_idle("rr31", 200);
    check("rr_frames", fd_cnt, fd_expect);

    // Transmitter still busy in IDLE: nothing granted until td_busy drops
    force_busy = 1'b1;
    request(0, 8'h96, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("busy_hold_send", send, 0);
      check("busy_hold_active", active, 0);
    end
    force_busy = 1'b0;
    step();
    check("grant_after_busy", send, 1);
    run_until_idle("busy", 100);

    // Stalled transmitter: timeout 16 cycles after the send cycle, no frame_done
    stall_mode = 1'b1;
    request(1, 8'h5A, 0);
    step();
    check("stall_send", send, 1);
    for (int j = 1; j <= 17; j++) begin
      step();
      if (j == 16) begin
        check("stall_err_early", timeout_err, 0);
        check("stall_active", active, 1);
      end
      if (j == 17) begin
        check("stall_err_set", timeout_err, 1);
        check("stall_back_idle", active, 0);
      end
    end
    check("stall_no_done", fd_cnt, fd_expect);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr", timeout_err, 0);

    // Clear in the same cycle as a new timeout: the set wins
    request(2, 8'hC3, 0);
    step();
    check("stall2_send", send, 1);
    for (int j = 1; j <= 17; j++) begin
      step();
      if (j == 16) begin
        check("stall2_err_early", timeout_err, 0);
        err_clr = 1'b1;
      end
    end
    err_clr = 1'b0;
    check("set_beats_clr", timeout_err, 1);
    step();
    check("err_sticky", timeout_err, 1);
    stall_mode = 1'b0;

    // Reset three cycles into WAIT_DONE drops the byte in flight
    request(3, 8'h3C, 1);
    step();
    check("mid_send", send, 1);
    step();
    repeat (3) step();
    check("mid_active", active, 1);
    check("mid_busy", td_busy, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_rst");
    fd_expect -= exp_tx.size();
    exp_tx.delete();
    exp_grant.delete();
    req_valid = '0;
    repeat (2) step();
    request(0, 8'h0F, 1);
    request(1, 8'hF0, 1);
    reset = 1'b1;
    run_until_idle("post_reset", 200);
    check("post_reset_frames", fd_cnt, fd_expect);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART `transmitter` between `N_REQ` byte producers. It accepts one byte from the selected requester and drives the transmitter's `tx_data`/`send` inputs. It holds `tx_data` stable for the whole frame and tracks `td_busy` to detect frame completion. It sits between the system-side byte sources and the `transmitter` instance, which connects to it directly.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles to wait for `td_busy` to rise after `send` before flagging an error, 2..255.
- `GW`, derived `$clog2(N_REQ)`: width of `grant_id`.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  bit i: requester i has a byte pending.
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-cycle pulse on bit i when requester i's byte is captured.
- `tx_data`  out  8  byte to transmitter; registered.
- `send`  out  1  one-cycle start pulse to transmitter.
- `td_busy`  in  1  transmitter busy status.
- `grant_id`  out  GW  index of requester owning the current frame.
- `active`  out  1  high whenever state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `timeout_err`  out  1  sticky error; set on busy timeout.
- `err_clr`  in  1  synchronous clear of `timeout_err`.

## Operation
- The FSM has four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- **IDLE**
  - Arbitration runs only when `td_busy`=0 and at least one `req_valid` bit is 1.
  - The winner is the first set bit searching from `last_grant+1`, wrapping modulo N_REQ.
  - On a grant: capture `req_data[winner]` into `tx_data`, set `grant_id`=winner, update `last_grant`=winner, register `req_ready[winner]`=1, and move to LAUNCH.
  - `req_valid` is ignored outside IDLE.
- **LAUNCH** lasts one cycle.
  - `send`=1 and `req_ready[grant_id]`=1 during this cycle.
  - Clear the timeout counter and move to WAIT_BUSY.
- **WAIT_BUSY**
  - If `td_busy`=1, move to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches BUSY_TIMEOUT, set `timeout_err`=1 and return to IDLE with no `frame_done`.
- **WAIT_DONE**
  - When `td_busy`=0, pulse `frame_done` for one cycle and return to IDLE.
- `tx_data` and `grant_id` change only on a grant. They hold their value through IDLE and the whole frame, because the transmitter reads `tx_data` bits throughout the frame.
- The timeout counter is 8 bits and saturates. It never wraps.
- `err_clr` and a new timeout in the same cycle: the set wins, so `timeout_err` stays 1.
- A requester must drop or update `req_valid`/`req_data` after its `req_ready` pulse. Otherwise it is granted again once the rotation returns to it.
- `td_busy`=1 while in IDLE (transmitter still finishing): no grant, no `req_ready`, and requests remain pending.

## Timing
- **Reset values** (`reset`=0, asynchronous):
  - state=IDLE, `last_grant`=N_REQ-1, so requester 0 wins first.
  - `tx_data`=8'h00, `send`=0, `req_ready`=0, `grant_id`=0.
  - `active`=0, `frame_done`=0, `timeout_err`=0, counter=0.
- **Reset mid-frame:** all outputs return to the values above immediately. After release the arbiter sits in IDLE until `td_busy`=0. A byte captured before reset is dropped with no retry.
- **Latency:**
  - Request valid at edge k in IDLE → `req_ready` and `send` high in cycle k+1.
  - The transmitter samples `send` at edge k+2, so `td_busy` is high from cycle k+2.
  - `frame_done` is high in the cycle after the first edge at which WAIT_DONE sees `td_busy`=0.
- **Throughput:** at least 2 IDLE/LAUNCH cycles between the fall of `td_busy` and the next `send`.
- `send` is never high in two consecutive cycles.
- At most one `req_ready` bit is high at a time.

## Test plan
- **Single request:** req_valid=4'b0100, req_data[23:16]=8'hA5.
  - req_ready=4'b0100 and send=1 in the same cycle; grant_id=2; tx_data=8'hA5 held until frame_done.
  - TXD carries 0, then bits of A5 LSB-first, then 1.
- **All four requesting continuously** after reset, with the model dropping each req_valid after its req_ready.
  - Grant order 0,1,2,3.
  - Re-raising req_valid[0] and [2] afterwards: grants 0 then 2.
- **Stalled transmitter:** td_busy tied 0 with BUSY_TIMEOUT=16.
  - timeout_err rises 16 cycles after the send cycle; no frame_done; back to IDLE.
  - err_clr=1 clears it next cycle; err_clr concurrent with a new timeout keeps it at 1.
- **td_busy forced 1 in IDLE** with req_valid=4'b0001.
  - No req_ready or send while busy.
  - Grant occurs the cycle after td_busy falls.
- **Reset mid-frame:** reset asserted 3 cycles into WAIT_DONE.
  - All outputs reset asynchronously.
  - After release, requester 0 is granted first, and the dropped byte is not resent.
